// File: rtl/uart_heater_ctrl.sv
// uart_heater_ctrl
//   Byte-level command controller for the RO heater. It decodes single-byte
//   host commands from the UART rx side into a per-channel heater enable
//   vector. It answers with one or more reply bytes on the UART tx side.
//   Both byte interfaces use a four-phase handshake.
//
// Ports
//   clk              single clock
//   Reset            synchronous, active-high
//   rx_receive       rx has a byte pending
//   rx_dout          received byte
//   rx_parity_err    parity error on the pending byte
//   rx_received      byte consumed (held until rx_receive drops)
//   tx_din           byte to transmit (stable while tx_send is high)
//   tx_send          transmit request
//   tx_sent          transmitter done
//   hbm_temperature  packed sensor readings, sensor i at [i*TEMP_W +: TEMP_W]
//   start            heater channel enables
//   busy             high whenever the controller is not idle
module uart_heater_ctrl #(
    parameter int NUM_CH      = 8,
    parameter int NUM_SENSORS = 2,
    parameter int TEMP_W      = 7
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          rx_receive,
    input  logic [7:0]                    rx_dout,
    input  logic                          rx_parity_err,
    output logic                          rx_received,
    output logic [7:0]                    tx_din,
    output logic                          tx_send,
    input  logic                          tx_sent,
    input  logic [NUM_SENSORS*TEMP_W-1:0] hbm_temperature,
    output logic [NUM_CH-1:0]             start,
    output logic                          busy
);

    localparam int TEMP_BYTES = (TEMP_W + 7) / 8;
    localparam int MASK_BYTES = (NUM_CH + 7) / 8;
    localparam int SNAP_W     = NUM_SENSORS * TEMP_W;
    localparam int TEMP_LEN   = NUM_SENSORS * TEMP_BYTES;
    // Reply staging vector: byte 0 of a reply sits in the top 8 bits.
    localparam int RV_W       = 128;

    localparam logic [3:0] TEMP_LEN_M1 = 4'(TEMP_LEN - 1);
    localparam logic [3:0] MASK_LEN_M1 = 4'(MASK_BYTES - 1);
    localparam logic [4:0] NUM_CH_L    = 5'(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RX_ACK = 2'd1,
        ST_SEND   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RK_CODE = 2'd0,
        RK_TEMP = 2'd1,
        RK_MASK = 2'd2
    } resp_kind_t;

    state_t                 state_q, state_d;
    resp_kind_t             kind_q, kind_d;
    logic [NUM_CH-1:0]      start_q, start_d;
    logic                   tx_send_q, tx_send_d;
    logic [7:0]             tx_din_q, tx_din_d;
    logic                   rx_received_q, rx_received_d;
    logic                   busy_q, busy_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             len_m1_q, len_m1_d;
    logic [7:0]             code_q, code_d;
    logic [SNAP_W-1:0]      snap_q, snap_d;

    logic [NUM_CH-1:0]      one_s;
    logic [NUM_CH-1:0]      ch_sel_s;
    logic                   ch_ok_s;
    logic [NUM_CH-1:0]      cmd_start_s;
    resp_kind_t             cmd_kind_s;
    logic [7:0]             cmd_code_s;
    logic [3:0]             cmd_len_m1_s;
    logic                   cmd_snap_s;
    logic [RV_W-1:0]        resp_vec_s;
    logic [TEMP_BYTES*8-1:0] temp_ext_s;
    logic [MASK_BYTES*8-1:0] mask_ext_s;

    // Selects reply byte idx from the staging vector (byte 0 is the MSB byte).
    function automatic logic [7:0] pick_byte(input logic [RV_W-1:0] v,
                                             input logic [3:0]      idx);
        logic [6:0] base;
        base = {~idx, 3'b000};
        return v[base +: 8];
    endfunction

    // Decodes the pending rx byte into its effect on start and its reply.
    always_comb begin
        one_s        = '0;
        one_s[0]     = 1'b1;
        ch_sel_s     = one_s << rx_dout[3:0];
        ch_ok_s      = ({1'b0, rx_dout[3:0]} < NUM_CH_L);
        cmd_start_s  = start_q;
        cmd_kind_s   = RK_CODE;
        cmd_code_s   = 8'h3F;
        cmd_len_m1_s = 4'd0;
        cmd_snap_s   = 1'b0;
        if (rx_parity_err) begin
            cmd_code_s = 8'h3F;
        end else if (rx_dout == 8'h40) begin
            cmd_start_s = '0;
            cmd_code_s  = 8'h52;
        end else if (rx_dout == 8'h30) begin
            cmd_start_s = '1;
            cmd_code_s  = 8'h41;
        end else if (rx_dout == 8'h31) begin
            cmd_start_s = '0;
            cmd_code_s  = 8'h42;
        end else if ((rx_dout[7:4] == 4'h5) && ch_ok_s) begin
            cmd_start_s = start_q | ch_sel_s;
            cmd_code_s  = 8'h41;
        end else if ((rx_dout[7:4] == 4'h6) && ch_ok_s) begin
            cmd_start_s = start_q & ~ch_sel_s;
            cmd_code_s  = 8'h42;
        end else if (rx_dout == 8'h2F) begin
            cmd_kind_s   = RK_TEMP;
            cmd_len_m1_s = TEMP_LEN_M1;
            cmd_snap_s   = 1'b1;
        end else if (rx_dout == 8'h32) begin
            cmd_kind_s   = RK_MASK;
            cmd_len_m1_s = MASK_LEN_M1;
        end else begin
            cmd_code_s = 8'h3F;
        end
    end

    // Lays out the latched reply (code, snapshot or mask) MSB byte first.
    always_comb begin
        resp_vec_s = '0;
        temp_ext_s = '0;
        mask_ext_s = '0;
        case (kind_q)
            RK_TEMP: begin
                for (int s = 0; s < NUM_SENSORS; s++) begin
                    temp_ext_s = '0;
                    temp_ext_s[TEMP_W-1:0] = snap_q[s*TEMP_W +: TEMP_W];
                    resp_vec_s[RV_W-1-s*TEMP_BYTES*8 -: TEMP_BYTES*8] = temp_ext_s;
                end
            end
            RK_MASK: begin
                // start cannot change while busy, so it is the latched mask.
                mask_ext_s[NUM_CH-1:0] = start_q;
                resp_vec_s[RV_W-1 -: MASK_BYTES*8] = mask_ext_s;
            end
            default: begin
                resp_vec_s[RV_W-1 -: 8] = code_q;
            end
        endcase
    end

    // Next-state logic for the rx/tx handshake sequencer.
    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        start_d       = start_q;
        tx_send_d     = tx_send_q;
        tx_din_d      = tx_din_q;
        rx_received_d = rx_received_q;
        cnt_d         = cnt_q;
        len_m1_d      = len_m1_q;
        code_d        = code_q;
        snap_d        = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_receive) begin
                    state_d       = ST_RX_ACK;
                    rx_received_d = 1'b1;
                    start_d       = cmd_start_s;
                    kind_d        = cmd_kind_s;
                    code_d        = cmd_code_s;
                    len_m1_d      = cmd_len_m1_s;
                    cnt_d         = 4'd0;
                    if (cmd_snap_s) begin
                        snap_d = hbm_temperature;
                    end else begin
                        snap_d = snap_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX_ACK: begin
                if (!rx_receive) begin
                    rx_received_d = 1'b0;
                    tx_din_d      = pick_byte(resp_vec_s, 4'd0);
                    tx_send_d     = 1'b1;
                    state_d       = ST_SEND;
                end else begin
                    state_d = ST_RX_ACK;
                end
            end
            ST_SEND: begin
                if (tx_sent) begin
                    tx_send_d = 1'b0;
                    state_d   = ST_GAP;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                // tx_send only re-asserts once tx_sent has been seen low.
                if (!tx_sent) begin
                    if (cnt_q != len_m1_q) begin
                        cnt_d     = cnt_q + 4'd1;
                        tx_din_d  = pick_byte(resp_vec_s, cnt_q + 4'd1);
                        tx_send_d = 1'b1;
                        state_d   = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            kind_q        <= RK_CODE;
            start_q       <= '0;
            tx_send_q     <= 1'b0;
            tx_din_q      <= 8'h00;
            rx_received_q <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= 4'd0;
            len_m1_q      <= 4'd0;
            code_q        <= 8'h00;
            snap_q        <= '0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            start_q       <= start_d;
            tx_send_q     <= tx_send_d;
            tx_din_q      <= tx_din_d;
            rx_received_q <= rx_received_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            len_m1_q      <= len_m1_d;
            code_q        <= code_d;
            snap_q        <= snap_d;
        end
    end

    assign start       = start_q;
    assign tx_send     = tx_send_q;
    assign tx_din      = tx_din_q;
    assign rx_received = rx_received_q;
    assign busy        = busy_q;

endmodule
